// File: rtl/fetch_queue.sv
// Instruction prefetch queue: credit-limited in-order fetch, DEPTH-entry buffer, redirect squash.
// Optional FETCHQ_BYPASS_EN forwards a response straight to the outputs when the buffer is empty.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  input  logic        deqReady,
  output logic        outValid,
  output logic [31:0] outInst,
  output logic [31:0] outPcPlus4,
  output logic        memReqValid,
  output logic [31:0] memReqAddr,
  input  logic        memReqReady,
  input  logic        memRespValid,
  input  logic [31:0] memRespData
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t        r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_drop_cnt;
  logic [31:0]   r_buf_inst [DEPTH];
  logic [31:0]   r_buf_pc4  [DEPTH];

  logic [CW:0]   w_credit;
  logic          w_req_valid;
  logic          w_req_acc;
  logic          w_resp_acc;
  logic          w_resp_run;
  logic          w_buf_valid;
  logic          w_bypass;
  logic          w_bypass_take;
  logic          w_deq;
  logic          w_enq;
  logic [CW-1:0] w_redir_inflight;

  // Slots already promised (buffered + outstanding) bound new requests, so a response always has room.
  assign w_credit    = {1'b0, r_count} + {1'b0, r_inflight};
  assign w_req_valid = rst && (r_state == RUN) && (w_credit < (CW+1)'(DEPTH));
  assign w_req_acc   = w_req_valid && memReqReady;
  assign w_resp_acc  = memRespValid && (r_inflight != '0);
  assign w_resp_run  = w_resp_acc && (r_state == RUN);
  assign w_buf_valid = (r_count != '0);

`ifdef FETCHQ_BYPASS_EN
  assign w_bypass      = !w_buf_valid && w_resp_run;
  assign w_bypass_take = w_bypass && deqReady && !redirect;
`else
  assign w_bypass      = 1'b0;
  assign w_bypass_take = 1'b0;
`endif

  assign w_deq = w_buf_valid && deqReady && !redirect;
  assign w_enq = w_resp_run && !redirect && !w_bypass_take;
  assign w_redir_inflight = r_inflight - CW'(w_resp_acc) + CW'(w_req_acc);

  assign memReqValid = w_req_valid;
  assign memReqAddr  = r_fetch_pc;
  assign outValid    = w_buf_valid || w_bypass;
  assign outInst     = w_bypass ? memRespData :
                       (w_buf_valid ? r_buf_inst[r_rd_ptr] : 32'h0);
  assign outPcPlus4  = w_bypass ? (r_resp_pc + 32'd4) :
                       (w_buf_valid ? r_buf_pc4[r_rd_ptr] : 32'h0);

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_buf_inst[r_wr_ptr] <= memRespData;
      r_buf_pc4[r_wr_ptr]  <= r_resp_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= RUN;
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_drop_cnt <= '0;
    end else if (redirect) begin
      // Everything still outstanding, including this cycle's accept, belongs to the old path.
      r_fetch_pc <= {redirectPc[31:2], 2'b00};
      r_resp_pc  <= {redirectPc[31:2], 2'b00};
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= w_redir_inflight;
      r_drop_cnt <= w_redir_inflight;
      r_state    <= (w_redir_inflight != '0) ? DRAIN : RUN;
    end else begin
      if (w_req_acc)  r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_resp_run) r_resp_pc  <= r_resp_pc + 32'd4;
      if (w_enq)      r_wr_ptr   <= r_wr_ptr + 1'b1;
      if (w_deq)      r_rd_ptr   <= r_rd_ptr + 1'b1;
      r_count    <= r_count + CW'(w_enq) - CW'(w_deq);
      r_inflight <= r_inflight + CW'(w_req_acc) - CW'(w_resp_acc);
      case (r_state)
        RUN: r_state <= RUN;
        DRAIN: begin
          if (w_resp_acc) begin
            r_drop_cnt <= r_drop_cnt - 1'b1;
            if (r_drop_cnt == CW'(1)) r_state <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: queue-level reference model plus directed literal checks.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirectPc = 32'h0;
  logic        deqReady = 1'b0;
  logic        outValid;
  logic [31:0] outInst;
  logic [31:0] outPcPlus4;
  logic        memReqValid;
  logic [31:0] memReqAddr;
  logic        memReqReady = 1'b0;
  logic        memRespValid = 1'b0;
  logic [31:0] memRespData = 32'h0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirectPc(redirectPc),
    .deqReady(deqReady), .outValid(outValid), .outInst(outInst),
    .outPcPlus4(outPcPlus4), .memReqValid(memReqValid), .memReqAddr(memReqAddr),
    .memReqReady(memReqReady), .memRespValid(memRespValid), .memRespData(memRespData)
  );

  always #5 clk = ~clk;

  // Reference model: buffered entries, outstanding requests (stale-tagged), next fetch address.
  logic [31:0] fq_inst[$];
  logic [31:0] fq_pc4[$];
  logic [31:0] os_addr[$];
  bit          os_stale[$];
  logic [31:0] m_fetch_pc = RESET_PC;
  bit          in_reset = 1'b1;
  // Memory model: accepted addresses with earliest response edge.
  logic [31:0] mem_addr[$];
  int          mem_rdy[$];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int p_ready = 100, p_resp = 100, p_deq = 100, p_redir_pm = 0, lat_min = 1, lat_max = 1;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic bit any_stale();
    foreach (os_stale[i]) if (os_stale[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_req_valid();
    return !in_reset && !any_stale() && (fq_inst.size() + os_addr.size() < DEPTH);
  endfunction

  task automatic compare();
    bit          ev;
    logic [31:0] ei, ep;
    ev = 1'b0; ei = 32'h0; ep = 32'h0;
    if (fq_inst.size() > 0) begin
      ev = 1'b1; ei = fq_inst[0]; ep = fq_pc4[0];
    end
`ifdef FETCHQ_BYPASS_EN
    else if (!in_reset && !any_stale() && memRespValid && os_addr.size() > 0) begin
      ev = 1'b1; ei = memRespData; ep = os_addr[0] + 32'd4;
    end
`endif
    check32("outValid", {31'b0, outValid}, {31'b0, ev});
    check32("memReqValid", {31'b0, memReqValid}, {31'b0, exp_req_valid()});
    check32("memReqAddr", memReqAddr, m_fetch_pc);
    if (ev) begin
      check32("outInst", outInst, ei);
      check32("outPcPlus4", outPcPlus4, ep);
    end
    if (in_reset) begin
      check32("rst_outInst", outInst, 32'h0);
      check32("rst_outPcPlus4", outPcPlus4, 32'h0);
    end
  endtask

  task automatic model_edge();
    bit          acc, resp, rs, took;
    logic [31:0] ra;
    if (in_reset) return;
    acc  = exp_req_valid() && memReqReady;
    resp = memRespValid && (os_addr.size() > 0);
    rs = 1'b0; ra = 32'h0; took = 1'b0;
    if (memRespValid && mem_addr.size() > 0) begin
      void'(mem_addr.pop_front());
      void'(mem_rdy.pop_front());
    end
    if (acc) begin
      mem_addr.push_back(m_fetch_pc);
      mem_rdy.push_back(cyc + $urandom_range(lat_max, lat_min));
    end
    if (resp) begin
      ra = os_addr.pop_front();
      rs = os_stale.pop_front();
    end
    if (acc) begin
      os_addr.push_back(m_fetch_pc);
      os_stale.push_back(1'b0);
    end
    if (redirect) begin
      fq_inst.delete();
      fq_pc4.delete();
      foreach (os_stale[i]) os_stale[i] = 1'b1;
      m_fetch_pc = {redirectPc[31:2], 2'b00};
    end else begin
      if (fq_inst.size() > 0 && deqReady) begin
        void'(fq_inst.pop_front());
        void'(fq_pc4.pop_front());
      end
`ifdef FETCHQ_BYPASS_EN
      else if (resp && !rs && deqReady) took = 1'b1;
`endif
      if (resp && !rs && !took) begin
        fq_inst.push_back(memRespData);
        fq_pc4.push_back(ra + 32'd4);
      end
      if (acc) m_fetch_pc = m_fetch_pc + 32'd4;
    end
  endtask

  task automatic drive();
    memReqReady = ($urandom_range(99) < p_ready);
    deqReady    = ($urandom_range(99) < p_deq);
    redirect    = ($urandom_range(999) < p_redir_pm);
    redirectPc  = $urandom;
    memRespValid = 1'b0;
    memRespData  = $urandom;
    if (!in_reset && mem_rdy.size() > 0 && mem_rdy[0] <= cyc + 1 &&
        $urandom_range(99) < p_resp) begin
      memRespValid = 1'b1;
      memRespData  = hash(mem_addr[0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    drive();
    #1 compare();
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b0;
    in_reset = 1'b1;
    fq_inst.delete(); fq_pc4.delete(); os_addr.delete(); os_stale.delete();
    mem_addr.delete(); mem_rdy.delete();
    m_fetch_pc = RESET_PC;
    redirect = 1'b0;
    memRespValid = 1'b0;
    #1 compare();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      #1 compare();
    end
    @(negedge clk);
    rst = 1'b1;
    in_reset = 1'b0;
    drive();
    #1 compare();
  endtask

  initial begin
    // Reset release with single-cycle memory and continuous dequeue.
    p_ready = 100; p_resp = 100; p_deq = 100; p_redir_pm = 0; lat_min = 1; lat_max = 1;
    do_reset(3);
    check32("lit_first_req_valid", {31'b0, memReqValid}, 32'd1);
    check32("lit_first_req_addr", memReqAddr, RESET_PC);
    for (int k = 1; k <= 6; k++) begin
      step();
      check32("lit_seq_addr", memReqAddr, 32'(4 * k));
`ifdef FETCHQ_BYPASS_EN
      check32("lit_seq_pc4", outPcPlus4, 32'(4 * k));
      check32("lit_seq_inst", outInst, hash(32'(4 * (k - 1))));
`else
      if (k >= 2) begin
        check32("lit_seq_pc4", outPcPlus4, 32'(4 * (k - 1)));
        check32("lit_seq_inst", outInst, hash(32'(4 * (k - 2))));
      end
`endif
    end

    // Consumer stalled: queue fills and requests stop.
    p_deq = 0;
    for (int k = 0; k < 10; k++) step();
    check32("lit_stall_req_valid", {31'b0, memReqValid}, 32'd0);
    check32("lit_stall_out_valid", {31'b0, outValid}, 32'd1);
    p_deq = 100;
    for (int k = 0; k < 8; k++) step();

    // Redirect with 3-cycle memory; unaligned target; concurrent dequeue ignored.
    lat_min = 3; lat_max = 3;
    for (int k = 0; k < 6; k++) step();
    @(posedge clk); cyc++; model_edge();
    @(negedge clk); drive();
    redirect = 1'b1; redirectPc = 32'h0000_0103; deqReady = 1'b1;
    #1 compare();
    step();
    check32("lit_redir_out_valid", {31'b0, outValid}, 32'd0);
    begin
      int t;
      t = 0;
      while (memReqValid !== 1'b1 && t < 30) begin step(); t++; end
      check32("lit_redir_wait_req", {31'b0, memReqValid}, 32'd1);
      check32("lit_redir_addr", memReqAddr, 32'h0000_0100);
      t = 0;
      while (outValid !== 1'b1 && t < 30) begin step(); t++; end
      check32("lit_redir_wait_out", {31'b0, outValid}, 32'd1);
      check32("lit_redir_pc4", outPcPlus4, 32'h0000_0104);
      check32("lit_redir_inst", outInst, hash(32'h0000_0100));
    end

    // Mid-stream reset pulse: next fetch restarts at RESET_PC.
    for (int k = 0; k < 3; k++) step();
    do_reset(2);
    check32("lit_rerst_addr", memReqAddr, RESET_PC);
    check32("lit_rerst_valid", {31'b0, memReqValid}, 32'd1);

    // Randomized traffic in segments with varying knobs.
    for (int seg = 0; seg < 20; seg++) begin
      p_ready    = $urandom_range(100, 30);
      p_resp     = $urandom_range(100, 30);
      p_deq      = $urandom_range(100, 20);
      p_redir_pm = $urandom_range(60, 0);
      lat_min    = $urandom_range(2, 1);
      lat_max    = lat_min + $urandom_range(3, 0);
      for (int k = 0; k < 200; k++) begin
        if ($urandom_range(499) == 0) do_reset(2);
        else step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
